gcd_engine: RTL and testbench

GCD_ENGINE -- requirements
Module: gcd_engine

---
 rtl/gcd_engine_pkg.sv | 20 ++
 rtl/gcd_engine.sv | 109 ++++++++++
 tb/tb_gcd_engine.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_engine_pkg.sv
// Shared definitions for the GCD engine and the LCM stage downstream of it.
package gcd_engine_pkg;

    // Default operand/result width.
    localparam int unsigned GCD_WIDTH = 16;

    // Controller states. The LCM stage reuses this encoding.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } gcd_state_e;

    // True when the subtractive iteration has reached its fixed point.
    function automatic logic gcd_finished(input logic [GCD_WIDTH-1:0] a,
                                          input logic [GCD_WIDTH-1:0] b);
        return (a == b) || (a == '0) || (b == '0);
    endfunction

endpackage

// File: rtl/gcd_engine.sv
// Subtractive GCD engine: start loads A/B, RUN subtracts the smaller from the larger
// until the operands meet or one reaches zero, then a single-cycle done pulse
// presents GCD_out and the step count. GCD_out feeds the LCM stage directly.
module gcd_engine
    import gcd_engine_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] GCD_out,
    output logic [WIDTH-1:0] steps
);

    gcd_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [WIDTH-1:0] steps_q, steps_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             finished;

    // Termination test on the working registers.
    always_comb begin
        finished = (a_q == b_q) || (a_q == '0) || (b_q == '0);
    end

    // Next-state and datapath update; busy/done are registered from the next state.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        gcd_d   = gcd_q;
        steps_d = steps_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (finished) begin
                    // One operand is zero or both are equal, so OR yields the survivor.
                    gcd_d   = a_q | b_q;
                    steps_d = cnt_q;
                    state_d = StDone;
                end else begin
                    if (a_q > b_q) begin
                        a_d = a_q - b_q;
                    end else begin
                        b_d = b_q - a_q;
                    end
                    // Saturate rather than wrap.
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            steps_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            steps_q <= steps_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign GCD_out = gcd_q;
    assign steps   = steps_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: the driver pushes expected results computed by
// a Euclidean (modulo-based) reference; a monitor pops them on each done pulse.
module tb_gcd_engine;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] GCD_out;
    logic [W-1:0] steps;

    gcd_engine #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .GCD_out (GCD_out),
        .steps   (steps)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned g;
        int unsigned s;
        int          done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int unsigned last_g = 0;
    int unsigned last_s = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: Euclid with modulo. The subtractive count equals the sum of the
    // quotients minus one, since the last quotient's final subtraction is replaced
    // by the equality test.
    function automatic void ref_gcd(input int unsigned a, input int unsigned b,
                                    output int unsigned g, output int unsigned s);
        int unsigned x, y, t, sum;
        if (a == 0 || b == 0) begin
            g = a + b;
            s = 0;
        end else begin
            x = a; y = b; sum = 0;
            while (y != 0) begin
                sum += x / y;
                t = x % y;
                x = y;
                y = t;
            end
            g = x;
            s = sum - 1;
            if (s > 32'hFFFF) s = 32'hFFFF;
        end
    endfunction

    // Monitor: compare each done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("gcd_out", GCD_out, e.g);
                check("steps", steps, e.s);
                check("done_cycle", cyc, e.done_cyc);
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].done_cyc) begin
            check("done_late", cyc, exp_q[0].done_cyc);
            void'(exp_q.pop_front());
        end
    end

    // Wait (bounded) until the DUT is idle; called at posedge+#1.
    task automatic wait_idle(input bit toggle_start);
        int n;
        n = 0;
        while (busy && n < 70000) begin
            if (toggle_start) begin
                start = ($urandom_range(0, 1) == 1);
                A = W'($urandom);
                B = W'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (busy) begin
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", n);
            $fatal(1);
        end
    endtask

    // Push the expectation for an operation accepted on edge acc.
    task automatic expect_op(input int unsigned a, input int unsigned b, input int acc,
                             output int done_cyc);
        exp_t e;
        ref_gcd(a, b, e.g, e.s);
        e.done_cyc = acc + int'(e.s) + 1;
        done_cyc = e.done_cyc;
        exp_q.push_back(e);
        last_g = e.g;
        last_s = e.s;
    endtask

    // Single operation; optionally pulse start while busy.
    task automatic issue(input int unsigned a, input int unsigned b, input bit noisy);
        int dc;
        wait_idle(1'b0);
        check("hold_gcd", GCD_out, last_g);
        check("hold_steps", steps, last_s);
        A = W'(a); B = W'(b); start = 1'b1;
        expect_op(a, b, cyc + 1, dc);
        @(posedge clk); #1;
        start = 1'b0;
        A = W'($urandom); B = W'($urandom);
        wait_idle(noisy);
    endtask

    // Start held high across done: second op accepted the cycle after done.
    task automatic issue_held(input int unsigned a1, input int unsigned b1,
                              input int unsigned a2, input int unsigned b2);
        int dc1, dc2, acc2;
        wait_idle(1'b0);
        A = W'(a1); B = W'(b1); start = 1'b1;
        expect_op(a1, b1, cyc + 1, dc1);
        @(posedge clk); #1;
        A = W'(a2); B = W'(b2);
        acc2 = dc1 + 2;
        expect_op(a2, b2, acc2, dc2);
        while (cyc < acc2) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        A = W'($urandom); B = W'($urandom);
        wait_idle(1'b0);
    endtask

    initial begin
        int dc;
        int unsigned ra, rb;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_gcd", GCD_out, 0);
        check("rst_steps", steps, 0);

        // First edge with rst=0 accepts (4,6).
        rst = 1'b0; start = 1'b1; A = 16'd4; B = 16'd6;
        expect_op(4, 6, cyc + 1, dc);
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(1'b0);

        issue(3, 5, 1'b0);
        issue(1, 1, 1'b0);
        issue(0, 9, 1'b0);
        issue(9, 0, 1'b0);
        issue(0, 0, 1'b0);
        issue(77, 77, 1'b0);
        issue(65535, 1, 1'b1);

        // Reset mid-RUN aborts without a done pulse.
        wait_idle(1'b0);
        A = 16'd4; B = 16'd8; start = 1'b1;
        expect_op(4, 8, cyc + 1, dc);
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        last_g = 0; last_s = 0;
        check("abort_busy", busy, 0);
        check("abort_gcd", GCD_out, 0);
        check("abort_steps", steps, 0);
        check("abort_done", done, 0);
        repeat (4) @(posedge clk);
        #1;
        issue(4, 8, 1'b0);

        issue_held(12, 18, 35, 21);
        issue_held(0, 5, 7, 7);

        for (int i = 0; i < 30; i++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            if (i % 3 == 0) issue_held(ra, rb, $urandom_range(1, 300), $urandom_range(1, 300));
            else issue(ra, rb, (i % 2 == 1));
        end

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
